targ_pred_arb: RTL and testbench

Arbiter and scheduler for the single-ported target prediction table. It shares the table port among `REQ_CNT` fetch-pipe lookup requesters. Resolved-branch feedback writes are buffered in a small FIFO and interleaved with lookups under a starvation bound. The block sits between the fetch pipes / branch resolution unit and the target prediction table, and it routes each table read response back to the requester that won the grant.

---
 rtl/targ_pred_arb_if.sv | 46 ++++
 rtl/targ_pred_arb.sv | 129 ++++++++++++
 tb/tb_targ_pred_arb.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/targ_pred_arb_if.sv
// Port bundle for targ_pred_arb: lookup requests, feedback writes,
// table access and lookup responses.
interface targ_pred_arb_if #(
  parameter int REQ_CNT = 3,
  parameter int ADDR_W  = 32,
  parameter int TIDX_W  = 1
);
  logic                           en;
  logic [TIDX_W-1:0]              table_index;
  logic [REQ_CNT-1:0]             req_valid;
  logic [REQ_CNT-1:0][ADDR_W-1:0] req_addr;
  logic [REQ_CNT-1:0]             req_ready;
  logic                           fb_valid;
  logic [ADDR_W-1:0]              fb_addr;
  logic [ADDR_W-1:0]              fb_targ;
  logic                           fb_ready;
  logic                           tp_ready;
  logic                           tp_valid;
  logic                           tp_write;
  logic [ADDR_W-1:0]              tp_addr;
  logic [ADDR_W-1:0]              tp_wtarg;
  logic [TIDX_W-1:0]              tp_tidx;
  logic [ADDR_W-1:0]              tp_rdata;
  logic                           tp_rhit;
  logic [REQ_CNT-1:0]             rsp_valid;
  logic [ADDR_W-1:0]              rsp_targ;
  logic                           rsp_hit;

  modport master (
    output en, table_index, req_valid, req_addr,
    output fb_valid, fb_addr, fb_targ,
    output tp_ready, tp_rdata, tp_rhit,
    input  req_ready, fb_ready,
    input  tp_valid, tp_write, tp_addr, tp_wtarg, tp_tidx,
    input  rsp_valid, rsp_targ, rsp_hit
  );

  modport slave (
    input  en, table_index, req_valid, req_addr,
    input  fb_valid, fb_addr, fb_targ,
    input  tp_ready, tp_rdata, tp_rhit,
    output req_ready, fb_ready,
    output tp_valid, tp_write, tp_addr, tp_wtarg, tp_tidx,
    output rsp_valid, rsp_targ, rsp_hit
  );
endinterface

// File: rtl/targ_pred_arb.sv
// Target prediction table port arbiter: round-robin lookups interleaved
// with buffered feedback writes under a starvation bound.
module targ_pred_arb #(
  parameter int REQ_CNT    = 3,
  parameter int FB_DEPTH   = 4,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 32,
  parameter int TIDX_W     = 1
) (
  input logic             clk,
  input logic             rst,
  targ_pred_arb_if.slave  bus
);
  localparam int PW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int FW = $clog2(FB_DEPTH);
  localparam int CW = FW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [PW-1:0]     rr_ptr;
  logic [FW-1:0]     wr_ptr;
  logic [FW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve;
  logic              rsp_pend;
  logic [PW-1:0]     rsp_id;
  logic [ADDR_W-1:0] fifo_addr [FB_DEPTH];
  logic [ADDR_W-1:0] fifo_targ [FB_DEPTH];

  logic          fifo_ne;
  logic          fifo_full;
  logic          any_req;
  logic          go;
  logic          do_wr;
  logic          do_rd;
  logic          push;
  logic          found;
  logic [PW-1:0] win;

  assign fifo_ne   = (count != '0);
  assign fifo_full = (count == CW'(FB_DEPTH));
  assign any_req   = |bus.req_valid;
  assign go        = rst && bus.en && bus.tp_ready;
  assign do_wr     = go && fifo_ne &&
                     (!any_req || fifo_full ||
                      starve == SW'(STARVE_MAX));
  assign do_rd     = go && !do_wr && any_req;
  assign push      = bus.fb_valid && bus.fb_ready;

  // Cyclic search for the first requester at or after rr_ptr
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      idx = (int'(rr_ptr) + i) % REQ_CNT;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    bus.tp_valid  = do_wr || do_rd;
    bus.tp_write  = do_wr;
    bus.tp_addr   = '0;
    bus.tp_wtarg  = '0;
    bus.req_ready = '0;
    unique case (1'b1)
      do_wr: begin
        bus.tp_addr  = fifo_addr[rd_ptr];
        bus.tp_wtarg = fifo_targ[rd_ptr];
      end
      do_rd: begin
        bus.tp_addr   = bus.req_addr[win];
        bus.req_ready = REQ_CNT'(1) << win;
      end
      default: ;
    endcase
  end

  assign bus.fb_ready  = rst && !fifo_full;
  assign bus.tp_tidx   = bus.table_index;
  assign bus.rsp_valid = rsp_pend ? (REQ_CNT'(1) << rsp_id) : '0;
  assign bus.rsp_targ  = rsp_pend ? bus.tp_rdata : '0;
  assign bus.rsp_hit   = rsp_pend && bus.tp_rhit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      starve   <= '0;
      rsp_pend <= 1'b0;
      rsp_id   <= '0;
    end else begin
      rsp_pend <= do_rd;
      if (do_rd) begin
        rsp_id <= win;
        rr_ptr <= (win == PW'(REQ_CNT - 1)) ? '0 : win + 1'b1;
        if (!fifo_ne)
          starve <= '0;
        else if (starve != SW'(STARVE_MAX))
          starve <= starve + 1'b1;
      end else if (do_wr) begin
        starve <= '0;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_wr)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, do_wr})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.fb_addr;
      fifo_targ[wr_ptr] <= bus.fb_targ;
    end
  end
endmodule

// File: tb/tb_targ_pred_arb.sv
// Scoreboard bench for targ_pred_arb: directed scenarios push expected
// table accesses and responses; a negedge monitor pops and compares.
module tb_targ_pred_arb;
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wtarg;
    logic [2:0]  rdy;
  } tp_t;

  typedef struct packed {
    logic [2:0]  v;
    logic [31:0] targ;
    logic        hit;
  } rsp_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  tp_t  tpq[$];
  rsp_t rspq[$];
  logic [31:0] addr_tab [3];
  logic        nv;
  logic [31:0] na;

  targ_pred_arb_if #(.REQ_CNT(3), .ADDR_W(32), .TIDX_W(1)) bus ();

  targ_pred_arb #(
    .REQ_CNT(3), .FB_DEPTH(4), .STARVE_MAX(8),
    .ADDR_W(32), .TIDX_W(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string n, logic [63:0] a,
                              logic [63:0] e);
    total++;
    if (a !== e)
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    else
      passed++;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(int w, logic [31:0] a, bit rsp);
    tpq.push_back(tp_t'{1'b0, a, 32'h0, 3'(1 << w)});
    if (rsp)
      rspq.push_back(rsp_t'{3'(1 << w), a + 32'hA7C, a[6]});
  endtask

  task automatic exp_wr(logic [31:0] a, logic [31:0] t);
    tpq.push_back(tp_t'{1'b1, a, t, 3'b000});
  endtask

  task automatic set_req(int i, logic [31:0] a);
    addr_tab[i]     = a;
    bus.req_addr[i] = a;
  endtask

  task automatic fb_push(logic [31:0] a, logic [31:0] t);
    bus.fb_valid = 1'b1;
    bus.fb_addr  = a;
    bus.fb_targ  = t;
    step();
    bus.fb_valid = 1'b0;
  endtask

  // Table model: read data one cycle after issue, junk otherwise
  always @(negedge clk) begin
    nv = rst && bus.tp_valid && !bus.tp_write;
    na = bus.tp_addr;
  end

  always @(posedge clk) begin
    #1;
    bus.tp_rdata = nv ? na + 32'hA7C : 32'hDEADBEEF;
    bus.tp_rhit  = nv ? na[6] : 1'b1;
  end

  always @(negedge clk) begin
    tp_t  et;
    rsp_t er;
    if (rst) begin
      if (bus.tp_valid) begin
        if (tpq.size() == 0) begin
          chk("tp_unexpected", 64'(bus.tp_valid), 64'(0));
        end else begin
          et = tpq.pop_front();
          chk("tp_write", 64'(bus.tp_write), 64'(et.wr));
          chk("tp_addr", 64'(bus.tp_addr), 64'(et.addr));
          chk("tp_wtarg", 64'(bus.tp_wtarg), 64'(et.wtarg));
          chk("req_ready", 64'(bus.req_ready), 64'(et.rdy));
        end
      end else if (bus.req_ready != 3'b000) begin
        chk("stray_req_ready", 64'(bus.req_ready), 64'(0));
      end
      if (bus.rsp_valid != 3'b000) begin
        if (rspq.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
        end else begin
          er = rspq.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(er.v));
          chk("rsp_targ", 64'(bus.rsp_targ), 64'(er.targ));
          chk("rsp_hit", 64'(bus.rsp_hit), 64'(er.hit));
        end
      end else begin
        chk("rsp_idle", 64'({bus.rsp_hit, bus.rsp_targ}), 64'(0));
      end
    end
  end

  initial begin
    rst             = 1'b0;
    bus.en          = 1'b1;
    bus.tp_ready    = 1'b1;
    bus.table_index = 1'b0;
    bus.req_valid   = 3'b111;
    bus.fb_valid    = 1'b0;
    bus.fb_addr     = '0;
    bus.fb_targ     = '0;
    bus.tp_rdata    = '0;
    bus.tp_rhit     = 1'b0;
    set_req(0, 32'h1000);
    set_req(1, 32'h2000);
    set_req(2, 32'h3000);

    // In reset: requests pending but nothing may leave
    @(negedge clk);
    chk("rst_fb_ready", 64'(bus.fb_ready), 64'(0));
    chk("rst_tp_valid", 64'(bus.tp_valid), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_targ", 64'(bus.rsp_targ), 64'(0));
    step();
    bus.req_valid = 3'b000;
    rst           = 1'b1;
    @(negedge clk);
    chk("post_fb_ready", 64'(bus.fb_ready), 64'(1));
    chk("post_tp_valid", 64'(bus.tp_valid), 64'(0));
    chk("post_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    step();

    // Round-robin
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_rd(k % 3, addr_tab[k % 3], 1'b1);
      step();
    end
    bus.req_valid = 3'b000;
    step();

    // Starvation bound
    bus.en = 1'b0;
    fb_push(32'h100, 32'h200);
    @(negedge clk);
    chk("sv_fb_ready", 64'(bus.fb_ready), 64'(1));
    step();
    bus.en        = 1'b1;
    bus.req_valid = 3'b001;
    for (int k = 0; k < 8; k++) begin
      exp_rd(0, addr_tab[0], 1'b1);
      step();
    end
    exp_wr(32'h100, 32'h200);
    step();
    exp_rd(0, addr_tab[0], 1'b1);
    step();
    bus.req_valid = 3'b000;
    step();

    // Full FIFO; fifth push refused despite same-cycle pop
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++)
      fb_push(32'h300 + 32'(4 * i), 32'h400 + 32'(i));
    bus.fb_valid  = 1'b1;
    bus.fb_addr   = 32'h3FF;
    bus.fb_targ   = 32'h4FF;
    bus.en        = 1'b1;
    bus.req_valid = 3'b011;
    exp_wr(32'h300, 32'h400);
    @(negedge clk);
    chk("full_fb_ready", 64'(bus.fb_ready), 64'(0));
    step();
    bus.fb_valid = 1'b0;
    exp_rd(1, addr_tab[1], 1'b1);
    @(negedge clk);
    chk("drain_fb_ready", 64'(bus.fb_ready), 64'(1));
    step();
    exp_rd(0, addr_tab[0], 1'b1);
    step();
    bus.req_valid = 3'b000;
    exp_wr(32'h304, 32'h401);
    step();
    exp_wr(32'h308, 32'h402);
    step();
    exp_wr(32'h30C, 32'h403);
    step();
    step();

    // Back-pressure
    bus.req_valid = 3'b111;
    bus.tp_ready  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
      chk("bp_tp_valid", 64'(bus.tp_valid), 64'(0));
      step();
    end
    bus.tp_ready = 1'b1;
    exp_rd(1, addr_tab[1], 1'b1);
    step();
    exp_rd(2, addr_tab[2], 1'b1);
    step();
    bus.req_valid = 3'b000;
    step();

    // Response pass-through: 0x40 -> rdata 0xABC, hit 1
    set_req(2, 32'h40);
    bus.table_index = 1'b1;
    bus.req_valid   = 3'b100;
    exp_rd(2, 32'h40, 1'b1);
    @(negedge clk);
    chk("tp_tidx", 64'(bus.tp_tidx), 64'(1));
    step();
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("pt_rsp_targ", 64'(bus.rsp_targ), 64'(32'hABC));
    step();
    bus.table_index = 1'b0;

    // Reset mid-flight with two queued feedback entries
    bus.en = 1'b0;
    fb_push(32'h500, 32'h600);
    fb_push(32'h504, 32'h604);
    bus.en        = 1'b1;
    bus.req_valid = 3'b001;
    exp_rd(0, addr_tab[0], 1'b0);
    step();
    rst           = 1'b0;
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("mr_rsp_targ", 64'(bus.rsp_targ), 64'(0));
    chk("mr_rsp_hit", 64'(bus.rsp_hit), 64'(0));
    chk("mr_tp_valid", 64'(bus.tp_valid), 64'(0));
    chk("mr_fb_ready", 64'(bus.fb_ready), 64'(0));
    chk("mr_req_ready", 64'(bus.req_ready), 64'(0));
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_post_fb_ready", 64'(bus.fb_ready), 64'(1));
    chk("mr_flushed", 64'(bus.tp_valid), 64'(0));
    step();
    step();

    chk("tp_queue_drained", 64'(tpq.size()), 64'(0));
    chk("rsp_queue_drained", 64'(rspq.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
